// File: rtl/sys_defs.sv
// Shared free-list sizing, storage typedef and port structs (NUM_PR, NUM_ARCH_TABLE, NUM_ROB, ZERO_REG overridable by macro).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef NUM_PR
`define NUM_PR 64
`endif
`ifndef NUM_ARCH_TABLE
`define NUM_ARCH_TABLE 32
`endif
`ifndef NUM_ROB
`define NUM_ROB 32
`endif
`ifndef ZERO_REG
`define ZERO_REG 31
`endif

package sys_defs;

  localparam int NUM_PR         = `NUM_PR;
  localparam int NUM_ARCH_TABLE = `NUM_ARCH_TABLE;
  localparam int NUM_ROB        = `NUM_ROB;
  localparam int ZERO_REG       = `ZERO_REG;

  // Physical registers not backing an architectural register at reset.
  // Must be a power of two so pointers wrap by plain overflow.
  localparam int NUM_FL = NUM_PR - NUM_ARCH_TABLE;

  localparam int PR_W   = $clog2(NUM_PR);
  localparam int ARCH_W = $clog2(NUM_ARCH_TABLE);
  localparam int ROB_W  = $clog2(NUM_ROB);
  localparam int FL_W   = $clog2(NUM_FL);
  localparam int PTR_W  = FL_W + 1;  // index plus wrap bit

  typedef logic [PR_W-1:0]   pr_tag_t;
  typedef logic [ARCH_W-1:0] arch_idx_t;
  typedef logic [ROB_W-1:0]  rob_idx_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;
  typedef logic [FL_W:0]     fl_cnt_t;

  // Free-list tag storage.
  typedef logic [PR_W-1:0] FL_t [NUM_FL];

  // Everything the dispatch/retire/recovery side hands the free list.
  typedef struct packed {
    logic      dispatch_en;
    arch_idx_t dest_idx;
    rob_idx_t  ROB_tail_idx;
    logic      retire_en;
    arch_idx_t retire_dest_idx;
    pr_tag_t   Told_idx;
    logic      rollback_en;
    rob_idx_t  ROB_rollback_idx;
  } FL_ROB_IN;

  // What the free list offers back to rename.
  typedef struct packed {
    pr_tag_t T_idx;
    logic    FL_valid;
    fl_cnt_t free_count;
  } FL_OUT;

  // Pointer increment: with a power-of-two depth, overflow into the top
  // bit is exactly the wrap-bit toggle.
  function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
    return p + fl_ptr_t'(1);
  endfunction

endpackage

// File: rtl/free_list.sv
// Circular free list of physical register tags with per-ROB-slot head snapshots for rollback; optional FL_BYPASS_EN forwards a retiring tag when empty.
// Latency: T_idx/FL_valid/free_count are combinational from state; alloc/free/rollback take effect at the next clock edge.
// Backpressure: FL_valid low means no tag; dispatch with FL_valid low does not allocate.
module free_list
  import sys_defs::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              dispatch_en,
  input  logic [ARCH_W-1:0] dest_idx,
  input  logic [ROB_W-1:0]  ROB_tail_idx,
  input  logic              retire_en,
  input  logic [ARCH_W-1:0] retire_dest_idx,
  input  logic [PR_W-1:0]   Told_idx,
  input  logic              rollback_en,
  input  logic [ROB_W-1:0]  ROB_rollback_idx,
  output logic [PR_W-1:0]   T_idx,
  output logic              FL_valid,
  output logic [FL_W:0]     free_count
);

  FL_ROB_IN in_s;
  FL_OUT    out_s;

  FL_t     entry;
  fl_ptr_t head;
  fl_ptr_t tail;
  fl_ptr_t snapshot [NUM_ROB];

  fl_ptr_t count;
  fl_ptr_t head_nxt;
  logic    empty;
  logic    zero_dest;
  logic    bypass_hit;
  logic    alloc;
  logic    free;
  logic    bypass_take;
  logic    dispatch_any;

  assign in_s = {dispatch_en, dest_idx, ROB_tail_idx, retire_en,
                 retire_dest_idx, Told_idx, rollback_en, ROB_rollback_idx};

  // Allocation/free decisions and the offered tag.
  always_comb begin
    count     = tail - head;
    empty     = (count == '0);
    zero_dest = (in_s.dest_idx == arch_idx_t'(ZERO_REG));
    free      = en & in_s.retire_en &
                (in_s.retire_dest_idx != arch_idx_t'(ZERO_REG));
`ifdef FL_BYPASS_EN
    // Empty list: a tag being retired this cycle can be handed straight out.
    bypass_hit = empty & free;
`else
    bypass_hit = 1'b0;
`endif
    out_s.FL_valid   = ~empty | bypass_hit;
    out_s.free_count = fl_cnt_t'(count);

    alloc = en & in_s.dispatch_en & ~zero_dest & out_s.FL_valid &
            ~in_s.rollback_en;
    // A forwarded tag never enters storage, so neither pointer moves.
    bypass_take  = bypass_hit & alloc;
    dispatch_any = en & in_s.dispatch_en & ~in_s.rollback_en &
                   (zero_dest | alloc);
    head_nxt     = (alloc & ~bypass_take) ? ptr_inc(head) : head;

    if (in_s.dispatch_en & zero_dest) begin
      out_s.T_idx = pr_tag_t'(ZERO_REG);
    end else if (bypass_hit) begin
      out_s.T_idx = in_s.Told_idx;
    end else begin
      out_s.T_idx = entry[head[FL_W-1:0]];
    end
  end

  assign T_idx      = out_s.T_idx;
  assign FL_valid   = out_s.FL_valid;
  assign free_count = out_s.free_count;

  // Head/tail pointers: rollback restores head, frees still advance tail.
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= fl_ptr_t'(NUM_FL);
    end else if (en) begin
      if (in_s.rollback_en) begin
        head <= snapshot[in_s.ROB_rollback_idx];
      end else begin
        head <= head_nxt;
      end
      if (free & ~bypass_take) begin
        tail <= ptr_inc(tail);
      end
    end
  end

  // Tag storage: retired tags are appended at the tail.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FL; i++) begin
        entry[i] <= pr_tag_t'(NUM_ARCH_TABLE + i);
      end
    end else if (en & free & ~bypass_take) begin
      entry[tail[FL_W-1:0]] <= in_s.Told_idx;
    end
  end

  // Snapshot the post-dispatch head for every dispatching ROB slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROB; i++) begin
        snapshot[i] <= '0;
      end
    end else if (dispatch_any) begin
      snapshot[in_s.ROB_tail_idx] <= head_nxt;
    end
  end

  // Retiring into a full list without a matching alloc would overwrite a live tag.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(free && !alloc && (count == fl_ptr_t'(NUM_FL))));

endmodule
